// File: rtl/seg_window_display.sv
// ============================================================================
// seg_window_display
// ----------------------------------------------------------------------------
// Purpose:
//   7-segment controller for a bank of N_DIGITS displays.
//   It latches a hex value of DATA_DIGITS nibbles and shows a window of
//   N_DIGITS consecutive nibbles from that value.
//   The window offset comes from one of two sources:
//     - manual: taken from the offset port and clamped to MAX_OFF;
//     - auto:   a step timer walks the offset from MAX_OFF down to 0,
//               then wraps back to MAX_OFF.
//   Each nibble has its own decimal point.
//
// Optional feature:
//   SEGDISP_LZB_EN  -- when defined, leading-zero blanking is enabled.
//                      Displays whose nibble index is above the most
//                      significant nonzero nibble go dark. Nibble 0 always
//                      shows, and the decimal point is never blanked.
//
// Ports:
//   clk        in   1              rising-edge clock
//   reset      in   1              asynchronous active-high reset
//   load       in   1              capture data/dp_in into the shadow regs
//   data       in   4*DATA_DIGITS  value to show, nibble 0 least significant
//   dp_in      in   DATA_DIGITS    decimal point per nibble
//   scroll_en  in   1              1 = auto-scroll, 0 = manual offset
//   offset     in   OW             manual window offset (nibbles)
//   seg        out  8*N_DIGITS     display i = seg[8i+7:8i], bit 7 = dp,
//                                  bits 6:0 = gfedcba, active-high
//   cur_offset out  OW             window offset currently shown on seg
// ============================================================================
module seg_window_display #(
    parameter int N_DIGITS    = 6,
    parameter int DATA_DIGITS = 8,
    parameter int STEP_CYCLES = 50_000_000,
    localparam int MAX_OFF    = DATA_DIGITS - N_DIGITS,
    localparam int OW         = (DATA_DIGITS > 1) ? $clog2(DATA_DIGITS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [4*DATA_DIGITS-1:0] data,
    input  logic [DATA_DIGITS-1:0]   dp_in,
    input  logic                     scroll_en,
    input  logic [OW-1:0]            offset,
    output logic [8*N_DIGITS-1:0]    seg,
    output logic [OW-1:0]            cur_offset
);

    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STEP_CYCLES - 1);
    localparam logic [OW-1:0] OFF_MAX  = OW'(MAX_OFF);

    // Segment decoder: nibble -> gfedcba, active-high.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h67;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [4*DATA_DIGITS-1:0] sh_data_q, sh_data_d;
    logic [DATA_DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [OW-1:0]            off_q, off_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     scroll_q;
    logic [8*N_DIGITS-1:0]    seg_q, seg_d;
    logic [OW-1:0]            cur_offset_q;
    logic [DATA_DIGITS-1:0]   keep;

    // ------------------------------------------------------------------
    // Shadow registers and window-offset next state
    // ------------------------------------------------------------------
    always_comb begin
        sh_data_d = sh_data_q;
        sh_dp_d   = sh_dp_q;
        off_d     = off_q;
        cnt_d     = cnt_q;

        if (load) begin
            sh_data_d = data;
            sh_dp_d   = dp_in;
        end

        if (!scroll_en) begin
            cnt_d = '0;
            off_d = (offset > OFF_MAX) ? OFF_MAX : offset;
        end else if (!scroll_q || load) begin
            // Entering auto mode, or new data arriving while in it:
            // restart from the most significant window. This overrides a
            // terminal count on the same edge.
            off_d = OFF_MAX;
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            off_d = (off_q == '0) ? OFF_MAX : off_q - OW'(1);
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero keep mask: keep[j] is 1 when some nibble at index j or
    // above is nonzero. Nibble 0 is always kept.
    // ------------------------------------------------------------------
`ifdef SEGDISP_LZB_EN
    always_comb begin
        logic acc;
        acc = 1'b0;
        for (int j = DATA_DIGITS - 1; j >= 0; j--) begin
            acc     = acc | (|sh_data_q[4*j +: 4]);
            keep[j] = acc | (j == 0);
        end
    end
`else
    assign keep = '1;
`endif

    // ------------------------------------------------------------------
    // Window select and decode. The window is taken from the registered
    // offset, so seg follows an offset or load change one edge later.
    // ------------------------------------------------------------------
    always_comb begin
        logic [3:0] nib;
        logic       dpb;
        logic       kp;
        seg_d = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            nib = '0;
            dpb = 1'b0;
            kp  = 1'b0;
            // off_q never exceeds MAX_OFF, so only those windows are muxed.
            for (int j = 0; j <= MAX_OFF; j++) begin
                if (off_q == OW'(j)) begin
                    nib = sh_data_q[4*(i+j) +: 4];
                    dpb = sh_dp_q[i+j];
                    kp  = keep[i+j];
                end
            end
            seg_d[8*i +: 8] = {dpb, hex_to_seg(nib) & {7{kp}}};
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_data_q    <= '0;
            sh_dp_q      <= '0;
            off_q        <= '0;
            cnt_q        <= '0;
            scroll_q     <= 1'b0;
            seg_q        <= '0;
            cur_offset_q <= '0;
        end else begin
            sh_data_q    <= sh_data_d;
            sh_dp_q      <= sh_dp_d;
            off_q        <= off_d;
            cnt_q        <= cnt_d;
            scroll_q     <= scroll_en;
            seg_q        <= seg_d;
            cur_offset_q <= off_q;
        end
    end

    assign seg        = seg_q;
    assign cur_offset = cur_offset_q;

endmodule

// File: tb/tb_seg_window_display.sv
module tb_seg_window_display;

    localparam int N_DIGITS    = 6;
    localparam int DATA_DIGITS = 8;
    localparam int STEP_CYCLES = 4;
    localparam int OW          = 3;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     load;
    logic [4*DATA_DIGITS-1:0] data;
    logic [DATA_DIGITS-1:0]   dp_in;
    logic                     scroll_en;
    logic [OW-1:0]            offset;
    logic [8*N_DIGITS-1:0]    seg;
    logic [OW-1:0]            cur_offset;

    int n_checks = 0;
    int n_fail   = 0;

    seg_window_display #(
        .N_DIGITS   (N_DIGITS),
        .DATA_DIGITS(DATA_DIGITS),
        .STEP_CYCLES(STEP_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .data      (data),
        .dp_in     (dp_in),
        .scroll_en (scroll_en),
        .offset    (offset),
        .seg       (seg),
        .cur_offset(cur_offset)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_seg(input string tag, input logic [47:0] exp);
        n_checks++;
        assert (seg === exp) else begin
            n_fail++;
            $error("FAIL %s: seg=%h expected %h", tag, seg, exp);
        end
    endtask

    task automatic check_off(input string tag, input logic [OW-1:0] exp);
        n_checks++;
        assert (cur_offset === exp) else begin
            n_fail++;
            $error("FAIL %s: cur_offset=%0d expected %0d", tag, cur_offset, exp);
        end
    endtask

    // Expectations that depend on leading-zero blanking.
`ifdef SEGDISP_LZB_EN
    localparam logic [47:0] ZERO_SHOW = 48'h00000000003F;
    localparam logic [47:0] EF_SHOW   = 48'h000000007971;
    localparam logic [47:0] DP_SHOW   = 48'h0000008000BF;
`else
    localparam logic [47:0] ZERO_SHOW = 48'h3F3F3F3F3F3F;
    localparam logic [47:0] EF_SHOW   = 48'h3F3F3F3F7971;
    localparam logic [47:0] DP_SHOW   = 48'h3F3F3FBF3FBF;
`endif

    initial begin
        reset     = 1'b1;
        load      = 1'b0;
        data      = '0;
        dp_in     = '0;
        scroll_en = 1'b0;
        offset    = '0;
        #1;
        check_seg("reset_seg", 48'h0);
        check_off("reset_off", 3'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        check_seg("cleared_shadow", ZERO_SHOW);

        // Manual mode, load with offset 2.
        data   = 32'hDEADBEEF;
        offset = 3'd2;
        load   = 1'b1;
        tick();
        load = 1'b0;
        check_seg("load_latency", ZERO_SHOW);
        tick();
        check_seg("manual_off2", 48'h5E79775E7C79);
        check_off("manual_off2_cur", 3'd2);

        offset = 3'd0;
        tick();
        check_off("offset_latency", 3'd2);
        tick();
        check_seg("manual_off0", 48'h775E7C797971);
        check_off("manual_off0_cur", 3'd0);

        offset = 3'd7;
        tick();
        tick();
        check_seg("manual_clamp", 48'h5E79775E7C79);
        check_off("manual_clamp_cur", 3'd2);

        offset = 3'd3;
        tick();
        tick();
        check_off("clamp_just_above", 3'd2);

        // Auto-scroll.
        offset = 3'd0;
        data   = 32'h12345678;
        load   = 1'b1;
        tick();
        load = 1'b0;
        tick();
        check_off("pre_scroll_off", 3'd0);
        scroll_en = 1'b1;
        tick();                            // edge k: off <- 2
        tick();                            // k+1
        check_off("scroll_k1", 3'd2);
        check_seg("scroll_seg_off2", 48'h065B4F666D7D);
        tick(); tick(); tick();            // k+4
        check_off("scroll_k4", 3'd2);
        tick();                            // k+5
        check_off("scroll_k5", 3'd1);
        check_seg("scroll_seg_off1", 48'h5B4F666D7D07);
        tick(); tick(); tick();            // k+8
        check_off("scroll_k8", 3'd1);
        tick();                            // k+9
        check_off("scroll_k9", 3'd0);
        check_seg("scroll_seg_off0", 48'h4F666D7D077F);
        tick(); tick(); tick(); tick();    // k+13
        check_off("scroll_wrap", 3'd2);
        tick();                            // k+14
        load = 1'b1;
        tick();                            // k+15: restart, cnt <- 0
        load = 1'b0;
        tick(); tick();                    // k+17
        check_off("load_restart_k17", 3'd2);
        tick(); tick();                    // k+19
        check_off("load_restart_k19", 3'd2);
        tick();                            // k+20
        check_off("load_restart_k20", 3'd1);

        // Asynchronous reset in the middle of scrolling.
        #2;
        reset = 1'b1;
        #1;
        check_seg("async_reset_seg", 48'h0);
        check_off("async_reset_off", 3'd0);
        tick();
        check_seg("held_reset_seg", 48'h0);
        reset     = 1'b0;
        scroll_en = 1'b0;
        offset    = 3'd0;
        tick();
        check_seg("after_release", ZERO_SHOW);
        check_off("after_release_off", 3'd0);

        // Leading zeros.
        data = 32'h000000EF;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        check_seg("lead_zero_EF", EF_SHOW);

        // Decimal points.
        data  = 32'h0;
        dp_in = 8'b0000_0101;
        load  = 1'b1;
        tick();
        load = 1'b0;
        tick();
        check_seg("decimal_points", DP_SHOW);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Backstop so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected end before 100000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seg_window_display.md
# seg_window_display

Parametrised 7-segment display controller for the DE10-Lite HEX bank. It latches a hex value that may have more digits than there are physical displays, and shows a window of N_DIGITS nibbles. The window is either chosen manually by offset or auto-scrolled by a step timer. Optional leading-zero blanking and per-digit decimal points are supported. It sits between datapath registers and the HEX0..HEXn pins, and is the successor to the fixed 6-digit combinational decoder bank.

## Interface

Parameters:
- N_DIGITS, 6: physical displays driven; ≥1.
- DATA_DIGITS, 8: nibbles in the latched value; ≥ N_DIGITS.
- STEP_CYCLES, 50_000_000: clock cycles per auto-scroll step; ≥1.
- Derived: MAX_OFF = DATA_DIGITS − N_DIGITS; OW = max(1, $clog2(DATA_DIGITS)).

Ports:
- clk, input, 1: the only clock; all state changes on its rising edge.
- reset, input, 1: asynchronous, active-high; clears all state immediately.
- load, input, 1: when high at an edge, capture data and dp_in into the shadow registers.
- data, input, 4*DATA_DIGITS: value to show; nibble j = data[4j+3:4j], nibble 0 least significant.
- dp_in, input, DATA_DIGITS: decimal point per nibble, captured with data.
- scroll_en, input, 1: 1 selects auto-scroll; 0 selects manual offset.
- offset, input, OW: manual window offset, in nibbles.
- seg, output, 8*N_DIGITS: display i = seg[8i+7:8i]; display 0 is rightmost. Active-high, bit order pgfe_dcba, with bit 7 as the decimal point.
- cur_offset, output, OW: window offset currently applied to seg.

## Operation

- Shadow registers sh_data and sh_dp load only on load; they hold otherwise.
- Window register off:
  - Manual mode (scroll_en=0): each edge, off ← min(offset, MAX_OFF).
  - Auto mode (scroll_en=1): a step counter counts 0..STEP_CYCLES−1.
  - At terminal count, off ← off−1, wrapping from 0 to MAX_OFF.
- Rising edge of scroll_en (0→1 between edges): off ← MAX_OFF and counter ← 0. Scrolling therefore starts showing the most significant nibbles.
- load while scroll_en=1: off ← MAX_OFF and counter ← 0. Load takes priority over a simultaneous terminal count.
- scroll_en=0: counter held at 0.
- MAX_OFF=0: off is always 0; auto mode has no visible effect.
- Display i shows nibble (i + off) of sh_data, decoded as follows:
  - 0..9 → 3F,06,5B,4F,66,6D,7D,07,7F,67
  - A..F → 77,7C,39,5E,79,71
- Bit 7 of display i = sh_dp[i + off].
- seg and cur_offset are registered.

## Timing

- Reset values:
  - seg = all 0 (all segments dark).
  - cur_offset = 0, off = 0, counter = 0.
  - sh_data = 0, sh_dp = 0.
- load sampled at edge k: shadow updates at edge k; seg reflects the new value at edge k+1.
- offset change sampled at edge k: off updates at k; seg and cur_offset update at k+1.
- Auto mode:
  - After scroll entry at edge k, off is MAX_OFF until edge k+STEP_CYCLES.
  - At that edge off becomes MAX_OFF−1, and so on every STEP_CYCLES edges.
- Reset asserted mid-scroll or mid-load: all registers clear at once. Display is dark until the first edge after release, when it shows the cleared shadow.
- No handshake: load is a level sampled every edge. Holding load high re-captures data every cycle.

## Configuration

- Macro SEGDISP_LZB_EN.
- Defined:
  - A display is blanked (segment bits 6:0 = 0) if its nibble index (i + off) is above the most significant nonzero nibble of sh_data.
  - Nibble 0 is never blanked.
  - If sh_data = 0, only the display holding nibble 0 (when it is in the window) shows 3F.
  - The decimal-point bit is unaffected by blanking.
- Not defined: every display shows its decoded nibble, zeros included.

## Test plan

- Defaults, manual mode. load data=32'hDEADBEEF, offset=2 → seg displays 5..0 = 5E,79,77,5E,7C,79 one edge after load; cur_offset=2.
- offset=0 → displays 5..0 = 77,5E,7C,79,79,71. Then offset=7 → clamped: same as offset=2, with cur_offset=2.
- STEP_CYCLES=4, data=32'h12345678, scroll_en 0→1:
  - cur_offset goes 2,1,0,2 at 4-edge intervals.
  - At off=2, displays 5..0 = 06,5B,4F,66,6D,7D.
  - A load mid-step restarts the sequence at 2.
- load 32'h000000EF, offset=0:
  - With SEGDISP_LZB_EN: displays 5..2 = 00, display1 = 79, display0 = 71.
  - Without it: displays 5..2 = 3F.
- dp_in=8'b0000_0101, data=0, offset=0 → display0 = BF, display2 = BF, others 3F (no macro).
- Reset asserted during auto-scroll → seg=0 and cur_offset=0 immediately, without waiting for a clock edge. After release, displays show 3F at the first edge (no macro).
